ber_checker_sync: RTL and testbench

//  Downstream of the FIR: decimates the signed (18,15) FIR output by OS at a selectable phase,

---
 rtl/ber_checker_sync.sv | 138 +++++++++++++
 tb/tb_ber_checker_sync.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker_sync.sv
// Decimating BER checker: slices one sample per symbol, searches the reference latency,
// then counts compared bits and bit errors once locked.
module ber_checker_sync #(
    parameter int NB_DATA  = 18,
    parameter int OS       = 4,
    parameter int NB_PHASE = 2,
    parameter int NB_LAT   = 9,
    parameter int SYNC_WIN = 511,
    parameter int NB_CNT   = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_ref_bit,
    input  logic [NB_PHASE-1:0] i_phase,
    output logic                o_sliced,
    output logic                o_locked,
    output logic [NB_LAT-1:0]   o_latency,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count
);
    localparam int DEPTH  = 2**NB_LAT - 1;
    localparam int NB_WIN = $clog2(SYNC_WIN + 1);

    localparam logic [NB_PHASE-1:0] CNT_LAST  = NB_PHASE'(OS - 1);
    localparam logic [NB_WIN-1:0]   WIN_LAST  = NB_WIN'(SYNC_WIN - 1);
    localparam logic [NB_CNT-1:0]   CNT_MAX   = '1;
    localparam logic                ST_SEARCH = 1'b0;
    localparam logic                ST_LOCKED = 1'b1;

    logic [NB_PHASE-1:0] cnt_q, cnt_d;
    logic [NB_PHASE-1:0] phase_q, phase_d;
    logic [DEPTH-1:0]    dl_q, dl_d;
    logic                sliced_q, sliced_d;
    logic                state_q, state_d;
    logic [NB_LAT-1:0]   lat_q, lat_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic                win_err_q, win_err_d;
    logic [NB_CNT-1:0]   bit_q, bit_d;
    logic [NB_CNT-1:0]   err_q, err_d;

    logic            strobe;
    logic            sliced_bit;
    logic            mismatch;
    logic [DEPTH:0]  ref_taps;

    // Index L of ref_taps is the reference bit from L strobes ago; index 0 is the live input.
    assign ref_taps = {dl_q, i_ref_bit};

    always_comb begin
        strobe     = i_valid && (cnt_q == phase_q);
        sliced_bit = ($signed(i_data) >= 0);
        mismatch   = sliced_bit ^ ref_taps[lat_q];

        cnt_d     = cnt_q;
        phase_d   = phase_q;
        dl_d      = dl_q;
        sliced_d  = sliced_q;
        state_d   = state_q;
        lat_d     = lat_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_d     = bit_q;
        err_d     = err_q;

        if (i_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = i_phase;
            end else begin
                cnt_d = cnt_q + NB_PHASE'(1);
            end
        end

        if (strobe) begin
            sliced_d = sliced_bit;
            dl_d     = {dl_q[DEPTH-2:0], i_ref_bit};
            case (state_q)
                ST_SEARCH: begin
                    if (win_cnt_q == WIN_LAST) begin
                        if (!win_err_q && !mismatch) begin
                            state_d = ST_LOCKED;
                        end else begin
                            lat_d = lat_q + NB_LAT'(1);
                        end
                        win_cnt_d = '0;
                        win_err_d = 1'b0;
                    end else begin
                        win_cnt_d = win_cnt_q + NB_WIN'(1);
                        win_err_d = win_err_q | mismatch;
                    end
                end
                default: begin
                    if (bit_q != CNT_MAX) begin
                        bit_d = bit_q + NB_CNT'(1);
                    end
                    if (mismatch && (err_q != CNT_MAX)) begin
                        err_d = err_q + NB_CNT'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            dl_q      <= '0;
            sliced_q  <= 1'b0;
            state_q   <= ST_SEARCH;
            lat_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= 1'b0;
            bit_q     <= '0;
            err_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            dl_q      <= dl_d;
            sliced_q  <= sliced_d;
            state_q   <= state_d;
            lat_q     <= lat_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
        end
    end

    assign o_sliced    = sliced_q;
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_latency   = lat_q;
    assign o_bit_count = bit_q;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_ber_checker_sync.sv
// Bench for ber_checker_sync: phase table, PRBS lock/error/reset/saturation sequences and a
// random uncorrelated run, all compared every cycle against a behavioural model.
module tb_ber_checker_sync;
    localparam int OS       = 4;
    localparam int SYNC_WIN = 16;
    localparam int NLAT     = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [17:0] data = '0;
    logic        ref_bit = 1'b0;
    logic [1:0]  phase = '0;

    logic        sliced, locked, sliced4, locked4;
    logic [8:0]  latency, latency4;
    logic [63:0] bit_cnt, err_cnt;
    logic [3:0]  bit_cnt4, err_cnt4;

    ber_checker_sync #(.NB_DATA(18), .OS(OS), .NB_PHASE(2), .NB_LAT(9), .SYNC_WIN(SYNC_WIN),
                       .NB_CNT(64)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_ref_bit(ref_bit),
        .i_phase(phase), .o_sliced(sliced), .o_locked(locked), .o_latency(latency),
        .o_bit_count(bit_cnt), .o_err_count(err_cnt)
    );

    ber_checker_sync #(.NB_DATA(18), .OS(OS), .NB_PHASE(2), .NB_LAT(9), .SYNC_WIN(SYNC_WIN),
                       .NB_CNT(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_ref_bit(ref_bit),
        .i_phase(phase), .o_sliced(sliced4), .o_locked(locked4), .o_latency(latency4),
        .o_bit_count(bit_cnt4), .o_err_count(err_cnt4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int              m_cnt, m_phase, m_lat, m_win_n, m_win_err;
    bit              m_sliced, m_locked;
    bit              m_hist[$];
    longint unsigned m_bits, m_errs;

    // Stimulus state
    logic [8:0] prbs_s = 9'h1FF;
    bit         tx[$];

    typedef struct {
        bit          valid;
        logic [17:0] data;
        logic [1:0]  phase;
        bit          exp_sliced;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [17:0] pos(input int i);
        return 18'(1000 + i);
    endfunction

    function automatic logic [17:0] neg(input int i);
        return 18'(-(1000 + i));
    endfunction

    task automatic model_tick(input bit r, input bit v, input logic [17:0] d, input bit rb,
                              input int ph);
        bit b, refb, mis;
        if (r) begin
            m_cnt = 0; m_phase = 0; m_lat = 0; m_win_n = 0; m_win_err = 0;
            m_sliced = 0; m_locked = 0; m_bits = 0; m_errs = 0;
            m_hist.delete();
            return;
        end
        if (!v) return;
        if (m_cnt == m_phase) begin
            b = ($signed(d) >= 0);
            if (m_lat == 0) refb = rb;
            else if (m_lat - 1 < int'(m_hist.size())) refb = m_hist[m_lat - 1];
            else refb = 1'b0;
            mis = (b != refb);
            m_sliced = b;
            if (m_locked) begin
                m_bits++;
                if (mis) m_errs++;
            end else begin
                m_win_n++;
                if (mis) m_win_err++;
                if (m_win_n == SYNC_WIN) begin
                    if (m_win_err == 0) m_locked = 1;
                    else m_lat = (m_lat + 1) % NLAT;
                    m_win_n = 0;
                    m_win_err = 0;
                end
            end
            m_hist.push_front(rb);
            if (m_hist.size() > NLAT - 1) void'(m_hist.pop_back());
        end
        m_cnt = (m_cnt + 1) % OS;
        if (m_cnt == 0) m_phase = ph;
    endtask

    task automatic check_all();
        check("sliced", sliced, m_sliced);
        check("locked", locked, m_locked);
        check("latency", latency, m_lat);
        check("bit_count", bit_cnt, m_bits);
        check("err_count", err_cnt, m_errs);
        check("bit_count_sat", bit_cnt4, (m_bits > 15) ? 15 : m_bits);
        check("err_count_sat", err_cnt4, (m_errs > 15) ? 15 : m_errs);
    endtask

    task automatic step(input bit r, input bit v, input logic [17:0] d, input bit rb,
                        input logic [1:0] ph);
        rst = r; valid = v; data = d; ref_bit = rb; phase = ph;
        model_tick(r, v, d, rb, int'(ph));
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 2'd0);
        step(1'b1, 1'b0, '0, 1'b0, 2'd0);
    endtask

    function automatic bit prbs_next();
        bit b;
        b = prbs_s[8] ^ prbs_s[4];
        prbs_s = {prbs_s[7:0], b};
        return b;
    endfunction

    // One symbol of looped-back PRBS: data carries the ref bit from 7 symbols earlier.
    task automatic prbs_symbol(input bit invert, input bit toggle);
        bit r, d;
        r = prbs_next();
        tx.push_front(r);
        d = (tx.size() > 7) ? tx[7] : 1'b0;
        if (tx.size() > 64) void'(tx.pop_back());
        d = d ^ invert;
        for (int k = 0; k < OS; k++) begin
            step(1'b0, 1'b1, d ? 18'sd16384 : -18'sd16384, r, 2'd0);
            if (toggle) step(1'b0, 1'b0, 18'($urandom), 1'($urandom), 2'd0);
        end
    endtask

    initial begin
        bit saw_wrap;
        logic [8:0] prev_lat;

        // Phase selection table: phase register starts at 0, 2 takes effect at the first
        // wrap, and the change to 3 at row 9 only applies after the next wrap.
        tbl[0]  = '{1'b1, pos(0),  2'd2, 1'b1};
        tbl[1]  = '{1'b1, neg(1),  2'd2, 1'b1};
        tbl[2]  = '{1'b1, neg(2),  2'd2, 1'b1};
        tbl[3]  = '{1'b1, neg(3),  2'd2, 1'b1};
        tbl[4]  = '{1'b1, neg(4),  2'd2, 1'b1};
        tbl[5]  = '{1'b1, neg(5),  2'd2, 1'b1};
        tbl[6]  = '{1'b1, neg(6),  2'd2, 1'b0};
        tbl[7]  = '{1'b1, pos(7),  2'd2, 1'b0};
        tbl[8]  = '{1'b1, pos(8),  2'd2, 1'b0};
        tbl[9]  = '{1'b1, pos(9),  2'd3, 1'b0};
        tbl[10] = '{1'b1, pos(10), 2'd3, 1'b1};
        tbl[11] = '{1'b1, neg(11), 2'd3, 1'b1};
        tbl[12] = '{1'b1, neg(12), 2'd3, 1'b1};
        tbl[13] = '{1'b1, neg(13), 2'd3, 1'b1};
        tbl[14] = '{1'b1, neg(14), 2'd3, 1'b1};
        tbl[15] = '{1'b1, neg(15), 2'd3, 1'b0};
        tbl[16] = '{1'b0, pos(16), 2'd3, 1'b0};
        tbl[17] = '{1'b1, pos(17), 2'd3, 1'b0};

        do_reset();
        check("reset_locked", locked, 0);
        check("reset_count", bit_cnt, 0);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].valid, tbl[i].data, 1'b0, tbl[i].phase);
            check($sformatf("table_sliced[%0d]", i), sliced, tbl[i].exp_sliced);
        end

        // PRBS loopback with 7-symbol delay: lock at latency 7 after 8 windows.
        do_reset();
        tx.delete();
        for (int n = 0; n < 160; n++) prbs_symbol(1'b0, 1'b0);
        check("lock_locked", locked, 1);
        check("lock_latency", latency, 7);
        check("lock_errs", err_cnt, 0);
        check("lock_bits", bit_cnt, 32);

        prbs_symbol(1'b1, 1'b0);
        check("one_err", err_cnt, 1);
        check("one_err_bits", bit_cnt, 33);
        for (int n = 0; n < 4; n++) prbs_symbol(1'b1, 1'b0);
        for (int n = 0; n < 3; n++) prbs_symbol(1'b0, 1'b0);
        check("five_err", err_cnt, 5);

        step(1'b1, 1'b0, '0, 1'b0, 2'd0);
        check("rst_locked", locked, 0);
        check("rst_err", err_cnt, 0);
        check("rst_bits", bit_cnt, 0);
        check("rst_lat", latency, 0);
        check("rst_sliced", sliced, 0);
        for (int n = 0; n < 160; n++) prbs_symbol(1'b0, 1'b0);
        check("relock_locked", locked, 1);
        check("relock_latency", latency, 7);

        // Force errors past the 4-bit counter range.
        for (int n = 0; n < 20; n++) prbs_symbol(1'b1, 1'b0);
        check("sat_err4", err_cnt4, 15);
        check("sat_err64", err_cnt, 20);
        for (int n = 0; n < 3; n++) prbs_symbol(1'b1, 1'b0);
        check("sat_err4_hold", err_cnt4, 15);

        // Valid toggling every cycle: same lock result as the continuous run.
        do_reset();
        tx.delete();
        prbs_s = 9'h1FF;
        for (int n = 0; n < 160; n++) prbs_symbol(1'b0, 1'b1);
        check("tog_locked", locked, 1);
        check("tog_latency", latency, 7);
        check("tog_bits", bit_cnt, 32);

        // Uncorrelated random data: search should sweep all latencies and wrap.
        do_reset();
        saw_wrap = 1'b0;
        prev_lat = latency;
        for (int c = 0; c < (NLAT + 8) * SYNC_WIN * OS; c++) begin
            step(1'b0, 1'b1, 18'($urandom), 1'($urandom), 2'($urandom));
            if (prev_lat == 9'd511 && latency == 9'd0) begin
                saw_wrap = 1'b1;
                break;
            end
            prev_lat = latency;
        end
        if (!m_locked) begin
            check("rand_wrap", saw_wrap, 1);
            check("rand_bits", bit_cnt, 0);
            check("rand_errs", err_cnt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
